// File: rtl/idex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : idex_pipe_stage
// Brief    : ID/EX pipeline stage carrying a packed control vector, three
//            register specifiers and NUM_DATA data words from decode to
//            execute. Valid/ready handshake with a 2-entry skid buffer so
//            that ready is a registered signal, plus synchronous flush for
//            branch/jump squash. Synchronous active-low reset.
// Options  : define PIPE_STATS_EN to add saturating stall/bubble counters
//            (stall_cnt, bubble_cnt ports and parameter CNT_W).
// Revision : 1.0 - initial release
// ============================================================================
module idex_pipe_stage #(
  parameter int CTRL_W   = 12,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4
`ifdef PIPE_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [REG_W-1:0]           in_rs,
  input  logic [REG_W-1:0]           in_rt,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [REG_W-1:0]           out_rs,
  output logic [REG_W-1:0]           out_rt,
  output logic [REG_W-1:0]           out_rd,
  output logic [NUM_DATA*DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
`endif
);

  // State encodes both valid bits: main valid in FULL/SKID, skid valid in SKID.
  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_full  = 2'd1;
  localparam logic [1:0] c_st_skid  = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       ready_q;

  logic [CTRL_W-1:0]          main_ctrl_q, skid_ctrl_q;
  logic [REG_W-1:0]           main_rs_q, main_rt_q, main_rd_q;
  logic [REG_W-1:0]           skid_rs_q, skid_rt_q, skid_rd_q;
  logic [NUM_DATA*DATA_W-1:0] main_data_q, skid_data_q;

  logic                       w_accept;
  logic                       w_drain;
  logic                       w_main_valid;
  logic                       w_load_main_in;
  logic                       w_load_main_skid;
  logic                       w_load_skid;

  assign w_main_valid = (state_q != c_st_empty);
  assign w_accept     = in_valid & ready_q;
  assign w_drain      = w_main_valid & out_ready;
  assign in_ready     = ready_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= c_st_empty;
    else      state_q <= state_d;
  end

  // Next-state and entry load selection; flush overrides every transition.
  always_comb begin
    state_d          = state_q;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (state_q)
      c_st_empty: begin
        if (w_accept) begin
          state_d        = c_st_full;
          w_load_main_in = 1'b1;
        end
      end
      c_st_full: begin
        if (w_drain && w_accept) begin
          w_load_main_in = 1'b1;
        end else if (w_drain) begin
          state_d = c_st_empty;
        end else if (w_accept) begin
          state_d     = c_st_skid;
          w_load_skid = 1'b1;
        end
      end
      c_st_skid: begin
        if (w_drain) begin
          state_d          = c_st_full;
          w_load_main_skid = 1'b1;
        end
      end
      default: state_d = c_st_empty;
    endcase
    if (flush) begin
      state_d          = c_st_empty;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // Outputs: control vector is zeroed for bubbles, other fields just held.
  always_comb begin
    out_valid = w_main_valid;
    out_ctrl  = w_main_valid ? main_ctrl_q : '0;
    out_rs    = main_rs_q;
    out_rt    = main_rt_q;
    out_rd    = main_rd_q;
    out_data  = main_data_q;
  end

  // Ready is registered from the next skid occupancy, held low in reset.
  always_ff @(posedge clk) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= (state_d != c_st_skid);
  end

  // Main entry: loads from the input or from the skid entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_ctrl_q <= '0;
      main_rs_q   <= '0;
      main_rt_q   <= '0;
      main_rd_q   <= '0;
      main_data_q <= '0;
    end else if (w_load_main_in) begin
      main_ctrl_q <= in_ctrl;
      main_rs_q   <= in_rs;
      main_rt_q   <= in_rt;
      main_rd_q   <= in_rd;
      main_data_q <= in_data;
    end else if (w_load_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_rs_q   <= skid_rs_q;
      main_rt_q   <= skid_rt_q;
      main_rd_q   <= skid_rd_q;
      main_data_q <= skid_data_q;
    end
  end

  // Skid entry: captures the input accepted while the main entry is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_ctrl_q <= '0;
      skid_rs_q   <= '0;
      skid_rt_q   <= '0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
    end else if (w_load_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_rs_q   <= in_rs;
      skid_rt_q   <= in_rt;
      skid_rd_q   <= in_rd;
      skid_data_q <= in_data;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

  // Saturating counters of stalled and empty output cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (w_main_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (!w_main_valid && (bubble_q != {CNT_W{1'b1}}))
        bubble_q <= bubble_q + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_idex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_pipe_stage
// Brief    : Directed self-checking bench for idex_pipe_stage: reset,
//            streaming, skid stall, flush, mid-operation reset and, with
//            PIPE_STATS_EN, the saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idex_pipe_stage;

  localparam int CTRL_W   = 12;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [CTRL_W-1:0]          in_ctrl;
  logic [REG_W-1:0]           in_rs, in_rt, in_rd;
  logic [NUM_DATA*DATA_W-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [CTRL_W-1:0]          out_ctrl;
  logic [REG_W-1:0]           out_rs, out_rt, out_rd;
  logic [NUM_DATA*DATA_W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PIPE_STATS_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic [3:0]  stall_cnt4, bubble_cnt4;
`endif

  idex_pipe_stage #(
    .CTRL_W(CTRL_W), .REG_W(REG_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_data(out_data)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STATS_EN
  logic                       s_in_ready, s_out_valid;
  logic [CTRL_W-1:0]          s_out_ctrl;
  logic [REG_W-1:0]           s_out_rs, s_out_rt, s_out_rd;
  logic [NUM_DATA*DATA_W-1:0] s_out_data;

  idex_pipe_stage #(
    .CTRL_W(CTRL_W), .REG_W(REG_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
    .CNT_W(4)
  ) dut_small (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_rs(s_out_rs), .out_rt(s_out_rt),
    .out_rd(s_out_rd), .out_data(s_out_data),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );
`endif

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NUM_DATA*DATA_W-1:0] mk_data(input logic [31:0] w0);
    return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
  endfunction

  // Present one instruction; register fields derive from the ctrl value.
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [31:0] w0);
    in_valid = v;
    in_ctrl  = c;
    in_rs    = c[4:0];
    in_rt    = c[9:5];
    in_rd    = c[4:0] ^ 5'h1f;
    in_data  = mk_data(w0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 12'hFFF, 32'hDEAD_BEEF);

    // Reset held two cycles with in_valid high.
    step(2);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_ctrl",  out_ctrl,  '0);
    check_eq("rst_out_data",  out_data,  '0);
    check_eq("rst_out_rs",    out_rs,    '0);
    check_eq("rst_in_ready",  in_ready,  1'b0);

    rst = 1'b1;
    drive(1'b0, '0, 32'h0);
    step();
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Streaming at one per cycle.
    out_ready = 1'b1;
    drive(1'b1, 12'h011, 32'h10);
    step();
    check_eq("str0_valid", out_valid, 1'b1);
    check_eq("str0_w0",    out_data[31:0], 32'h10);
    check_eq("str0_ctrl",  out_ctrl, 12'h011);
    check_eq("str0_ready", in_ready, 1'b1);
    drive(1'b1, 12'h022, 32'h20);
    step();
    check_eq("str1_w0",    out_data[31:0], 32'h20);
    check_eq("str1_ready", in_ready, 1'b1);
    drive(1'b1, 12'h033, 32'h30);
    step();
    check_eq("str2_data",  out_data, mk_data(32'h30));
    check_eq("str2_rd",    out_rd, 5'h13 ^ 5'h1f);
    check_eq("str2_ready", in_ready, 1'b1);
    drive(1'b0, '0, 32'h0);
    step();
    check_eq("str_end_valid", out_valid, 1'b0);
    check_eq("str_end_ctrl",  out_ctrl, '0);

    // Stall with skid: A then B while execute is blocked.
    out_ready = 1'b0;
    drive(1'b1, 12'hAAA, 32'hA1);
    step();
    check_eq("stl_a_ctrl",  out_ctrl, 12'hAAA);
    check_eq("stl_a_ready", in_ready, 1'b1);
    drive(1'b1, 12'hBBB, 32'hB2);
    step();
    check_eq("stl_b_hold",  out_data[31:0], 32'hA1);
    check_eq("stl_b_ready", in_ready, 1'b0);
    drive(1'b1, 12'hCCC, 32'hC3);
    step();
    check_eq("stl_hold_ctrl", out_ctrl, 12'hAAA);
    check_eq("stl_hold_data", out_data, mk_data(32'hA1));
    check_eq("stl_hold_rs",   out_rs, 5'h0A);
    drive(1'b0, '0, 32'h0);
    out_ready = 1'b1;
    step();
    check_eq("stl_out_b_ctrl", out_ctrl, 12'hBBB);
    check_eq("stl_out_b_data", out_data, mk_data(32'hB2));
    check_eq("stl_out_b_rt",   out_rt, 5'h1D);
    check_eq("stl_ready_back", in_ready, 1'b1);
    step();
    check_eq("stl_empty_valid", out_valid, 1'b0);

    // Flush while both entries are held, with C presented the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 12'hAAA, 32'hA1);
    step();
    drive(1'b1, 12'hBBB, 32'hB2);
    step();
    check_eq("fl_pre_ready", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 12'hCCC, 32'hC3);
    step();
    flush = 1'b0;
    check_eq("fl_valid", out_valid, 1'b0);
    check_eq("fl_ctrl",  out_ctrl, '0);
    check_eq("fl_ready", in_ready, 1'b1);
    drive(1'b0, '0, 32'h0);
    out_ready = 1'b1;
    step();
    check_eq("fl_no_c_valid", out_valid, 1'b0);

    // Reset in the middle of a stalled transfer.
    out_ready = 1'b0;
    drive(1'b1, 12'hAAA, 32'hA1);
    step();
    drive(1'b1, 12'hBBB, 32'hB2);
    step();
    drive(1'b0, '0, 32'h0);
    rst = 1'b0;
    step();
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_ctrl",  out_ctrl, '0);
    check_eq("mrst_data",  out_data, '0);
    check_eq("mrst_rd",    out_rd, '0);
    check_eq("mrst_ready", in_ready, 1'b0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    check_eq("mrst_rel_ready", in_ready, 1'b1);
    check_eq("mrst_rel_valid", out_valid, 1'b0);
    step();
    check_eq("mrst_no_ab", out_valid, 1'b0);

`ifdef PIPE_STATS_EN
    // Counters: reset, one bubble edge, one accept edge, then stall.
    rst = 1'b0;
    step();
    check_eq("st_rst_stall", stall_cnt, '0);
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, 32'h0);
    step();
    drive(1'b1, 12'h123, 32'h55);
    step();
    drive(1'b0, '0, 32'h0);
    step(5);
    check_eq("st_stall5",  stall_cnt, 16'd5);
    check_eq("st_bubble2", bubble_cnt, 16'd2);
    check_eq("st4_stall5", stall_cnt4, 4'd5);
    step(15);
    check_eq("st_stall20", stall_cnt, 16'd20);
    check_eq("st4_sat",    stall_cnt4, 4'd15);
    check_eq("st_bubble_hold", bubble_cnt, 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
Parametrised ID/EX pipeline stage that replaces the fixed-field, always-load ID/EX register. Carries a packed control vector, three register-specifier fields and NUM_DATA data words from decode to execute. Uses a valid/ready handshake with a 2-entry skid buffer, so hazard stalls back-pressure decode without combinational ready paths. Supports synchronous flush (bubble insertion) for branch and jump squash.

Parameters:
CTRL_W, 12, width of packed control vector (RegWrite, MemWrite, MemRead, PCsrc, ALUsrc, RegDst, ALUop, MemtoReg, ...)
REG_W, 5, width of each register specifier (rs, rt, rd)
DATA_W, 32, width of each data word
NUM_DATA, 4, number of data words (pc+4, rdata1, rdata2, sign-ext imm by default)
CNT_W, 16, width of statistics counters (only used with PIPE_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (stage is reset when rst==0 at a rising clk edge)
flush  in  1  squash all held entries this cycle
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept; registered
in_ctrl  in  CTRL_W  control vector
in_rs  in  REG_W  source reg 1
in_rt  in  REG_W  source reg 2
in_rd  in  REG_W  destination reg
in_data  in  NUM_DATA*DATA_W  packed data words, word 0 in LSBs
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute accepts entry
out_ctrl  out  CTRL_W  control vector; all-zero whenever out_valid==0
out_rs, out_rt, out_rd  out  REG_W each  register specifiers
out_data  out  NUM_DATA*DATA_W  data words
stall_cnt  out  CNT_W  (PIPE_STATS_EN only) stall cycles
bubble_cnt  out  CNT_W  (PIPE_STATS_EN only) bubble cycles

Behaviour:
- Storage: main entry (drives outputs) plus skid entry, each with its own valid bit. in_ready = !skid_valid (register-derived). While rst==0, in_ready is forced 0.
- States: EMPTY (no valid entries), FULL (main valid), SKID (main and skid valid).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept -> main<=input, go to FULL. Latency is 1 cycle from input to output.
- FULL, drain & accept: main<=input, stay FULL. This sustains 1 instruction/cycle.
- FULL, drain & !accept: go to EMPTY.
- FULL, !drain & accept: skid<=input, go to SKID. in_ready drops next cycle.
- FULL, !drain & !accept: hold.
- SKID: in_ready==0, so no accept. Drain -> main<=skid, skid_valid<=0, go to FULL. in_ready rises next cycle. !drain -> hold.
- Held entries never change while not drained. out_* are stable while out_valid & !out_ready.
- flush==1: both valid bits cleared and the stage goes to EMPTY next cycle. Any same-cycle input is dropped, and so is any same-cycle drain's successor. Flush has priority over all transitions.
- Bubble semantics: out_ctrl is forced to 0 when out_valid==0, so downstream sees no RegWrite or MemWrite. out_rs/rt/rd/data are held when out_valid==0 (don't-care, not cleared).
- Reset (rst==0 at edge): both valid bits 0, all stored fields 0, out_* all 0, counters 0. Next state is EMPTY. Reset mid-transfer discards both entries; no partial state survives.
- Counters saturate at 2^CNT_W-1 (no wrap).

Optional Feature:
Macro PIPE_STATS_EN.
- Defined: stall_cnt increments each cycle with out_valid & !out_ready. bubble_cnt increments each cycle with out_valid==0 after reset. Both saturate and are cleared by reset only.
- Not defined: stall_cnt and bubble_cnt ports and all counter logic are absent.

Test Plan:
- Reset: hold rst=0 two cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0. After rst=1, in_ready=1 next cycle.
- Streaming: out_ready=1, in_valid=1 with in_data words 0x10,0x20,0x30 on 3 consecutive cycles -> out_valid from cycle+1, out_data word0 = 0x10,0x20,0x30 in order, in_ready constant 1.
- Stall/skid: out_ready=0, push A then B -> A at outputs, in_ready=0 after B accepted. Raise out_ready -> A, then B emitted in order, no loss or duplication, in_ready back to 1.
- Flush in SKID: A in main, B in skid, flush=1 with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, C not emitted, in_ready=1.
- Reset mid-operation: state SKID, assert rst=0 one cycle -> out_valid=0, all outputs 0, state EMPTY. Neither A nor B ever appears.
- PIPE_STATS_EN: out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated).
